// File: rtl/uart_hasti_bridge_if.sv
// HASTI (AHB-lite) master bus bundle used by the UART debug bridge.
// Width macros default to a 32-bit word bus unless the platform header set them already.

`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif

interface uart_hasti_bridge_if;
    logic [`HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                          hwrite;
    logic [`HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [`HASTI_BURST_WIDTH-1:0] hburst;
    logic                          hmastlock;
    logic [`HASTI_PROT_WIDTH-1:0]  hprot;
    logic [`HASTI_TRANS_WIDTH-1:0] htrans;
    logic [`HASTI_BUS_WIDTH-1:0]   hwdata;
    logic [`HASTI_BUS_WIDTH-1:0]   hrdata;
    logic                          hready;
    logic                          hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/uart_hasti_bridge.sv
// UART-to-HASTI debug initiator: decodes 8N1 'W'/'R' command frames from RXD,
// performs one single-word bus transfer, and answers on TXD.

module uart_hasti_bridge #(
    parameter int unsigned BAUD_DIV     = 5208,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic hclk,
    input  logic rst,
    input  logic RXD,
    output logic TXD,
    output logic busy,
    uart_hasti_bridge_if.master bus
);

    localparam logic [15:0] BAUD_LAST    = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST    = 16'(BAUD_DIV / 2 - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * BAUD_DIV - 1);
    localparam logic [7:0]  CMD_WRITE    = 8'h57;
    localparam logic [7:0]  CMD_READ     = 8'h52;
    localparam logic [7:0]  RESP_OK      = 8'h4B;
    localparam logic [7:0]  RESP_ERR     = 8'h45;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_ADDR, BUS_DATA, SEND} state_e;

    logic [2:0]  rxdSync_q;
    logic        rxdNow;
    logic        rxdFall;

    rxState_e    rxState_q, rxState_d;
    logic [15:0] rxCnt_q, rxCnt_d;
    logic [2:0]  rxIdx_q, rxIdx_d;
    logic [7:0]  rxShift_q, rxShift_d;
    logic        rxDone;
    logic        rxFrameErr;

    state_e      state_q, state_d;
    logic [1:0]  byteCnt_q, byteCnt_d;
    logic        isWrite_q, isWrite_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] respBuf_q, respBuf_d;
    logic [2:0]  respLen_q, respLen_d;
    logic [31:0] toCnt_q, toCnt_d;
    logic [9:0]  txFrame_q, txFrame_d;
    logic [15:0] txCnt_q, txCnt_d;
    logic [3:0]  txBits_q, txBits_d;
    logic        txd_q, txd_d;

    assign rxdNow  = rxdSync_q[1];
    assign rxdFall = rxdSync_q[2] & ~rxdSync_q[1];

    // Bring the asynchronous RX line into hclk; the third stage gives edge detection.
    always_ff @(posedge hclk or posedge rst) begin
        if (rst) rxdSync_q <= 3'b111;
        else     rxdSync_q <= {rxdSync_q[1:0], RXD};
    end

    // Receiver state and bit-timing registers.
    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxIdx_q   <= '0;
            rxShift_q <= '0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxIdx_q   <= rxIdx_d;
            rxShift_q <= rxShift_d;
        end
    end

    // Receiver: mid-bit sampling, glitch rejection on the start bit, stop-bit check.
    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q + 16'd1;
        rxIdx_d    = rxIdx_q;
        rxShift_d  = rxShift_q;
        rxDone     = 1'b0;
        rxFrameErr = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                rxCnt_d = '0;
                if (rxdFall) rxState_d = RX_START;
            end
            RX_START: begin
                if (rxCnt_q == HALF_LAST) begin
                    rxCnt_d   = '0;
                    rxIdx_d   = '0;
                    rxState_d = rxdNow ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == BAUD_LAST) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxdNow, rxShift_q[7:1]};
                    rxIdx_d   = rxIdx_q + 3'd1;
                    if (rxIdx_q == 3'd7) rxState_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == BAUD_LAST) begin
                    rxCnt_d   = '0;
                    rxState_d = RX_IDLE;
                    if (rxdNow) rxDone     = 1'b1;
                    else        rxFrameErr = 1'b1;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Command FSM, frame buffers and transmitter registers.
    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            byteCnt_q <= '0;
            isWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            respBuf_q <= '0;
            respLen_q <= '0;
            toCnt_q   <= '0;
            txFrame_q <= '1;
            txCnt_q   <= '0;
            txBits_q  <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            respBuf_q <= respBuf_d;
            respLen_q <= respLen_d;
            toCnt_q   <= toCnt_d;
            txFrame_q <= txFrame_d;
            txCnt_q   <= txCnt_d;
            txBits_q  <= txBits_d;
            txd_q     <= txd_d;
        end
    end

    // Frame decode, inter-byte timeout, bus handshake and response serialisation.
    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        respBuf_d = respBuf_q;
        respLen_d = respLen_q;
        toCnt_d   = '0;
        txFrame_d = txFrame_q;
        txCnt_d   = txCnt_q;
        txBits_d  = txBits_q;
        case (state_q)
            IDLE: begin
                if (rxDone && (rxShift_q == CMD_WRITE || rxShift_q == CMD_READ)) begin
                    state_d   = GET_ADDR;
                    isWrite_d = (rxShift_q == CMD_WRITE);
                    byteCnt_d = '0;
                end
            end
            GET_ADDR, GET_DATA: begin
                if (rxState_q == RX_IDLE) toCnt_d = toCnt_q + 32'd1;
                if (rxFrameErr) begin
                    state_d = IDLE;
                end else if (rxDone) begin
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (state_q == GET_ADDR) addr_d  = {rxShift_q, addr_q[31:8]};
                    else                     wdata_d = {rxShift_q, wdata_q[31:8]};
                    if (byteCnt_q == 2'd3)
                        state_d = (state_q == GET_ADDR && isWrite_q) ? GET_DATA : BUS_ADDR;
                end else if (toCnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end
            end
            BUS_ADDR: begin
                if (bus.hready) state_d = BUS_DATA;
            end
            BUS_DATA: begin
                if (bus.hready) begin
                    state_d = SEND;
                    if (bus.hresp) begin
                        respBuf_d = {24'h0, RESP_ERR};
                        respLen_d = 3'd1;
                    end else if (isWrite_q) begin
                        respBuf_d = {24'h0, RESP_OK};
                        respLen_d = 3'd1;
                    end else begin
                        respBuf_d = bus.hrdata;
                        respLen_d = 3'd4;
                    end
                    txFrame_d = {1'b1, respBuf_d[7:0], 1'b0};
                    txCnt_d   = '0;
                    txBits_d  = '0;
                end
            end
            SEND: begin
                txCnt_d = txCnt_q + 16'd1;
                if (txCnt_q == BAUD_LAST) begin
                    txCnt_d = '0;
                    if (txBits_q == 4'd9) begin
                        if (respLen_q > 3'd1) begin
                            respBuf_d = {8'h0, respBuf_q[31:8]};
                            respLen_d = respLen_q - 3'd1;
                            txFrame_d = {1'b1, respBuf_d[7:0], 1'b0};
                            txBits_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        txFrame_d = {1'b1, txFrame_q[9:1]};
                        txBits_d  = txBits_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == SEND) ? txFrame_d[0] : 1'b1;
    end

    assign TXD           = txd_q;
    assign busy          = (state_q != IDLE);
    assign bus.haddr     = addr_q & ~32'h3;
    assign bus.hwrite    = (state_q == BUS_ADDR) && isWrite_q;
    assign bus.htrans    = (state_q == BUS_ADDR) ? 2'b10 : 2'b00;
    assign bus.hwdata    = wdata_q;
    assign bus.hsize     = 3'b010;
    assign bus.hburst    = 3'b000;
    assign bus.hmastlock = 1'b0;
    assign bus.hprot     = 4'b0011;

endmodule

// File: tb/tb_uart_hasti_bridge.sv
// Bench for uart_hasti_bridge: drives serial frames, plays an AHB-lite slave,
// decodes TXD, and compares against a frame-level reference model.

module tb_uart_hasti_bridge;

    localparam int BAUD = 16;
    localparam int TOBITS = 64;

    logic hclk = 1'b0;
    logic rst;
    logic RXD;
    wire  TXD;
    wire  busy;

    uart_hasti_bridge_if bus();

    uart_hasti_bridge #(.BAUD_DIV(BAUD), .TIMEOUT_BITS(TOBITS)) dut (
        .hclk (hclk),
        .rst  (rst),
        .RXD  (RXD),
        .TXD  (TXD),
        .busy (busy),
        .bus  (bus)
    );

    always #5 hclk = ~hclk;

    int compared = 0;
    int mismatched = 0;

    int          slvWait = 0;
    bit          slvErr = 0;
    logic [31:0] slvRdata = '0;

    logic [31:0] txnAddr[$];
    bit          txnWrite[$];
    bit          txnBusy[$];
    logic [31:0] txnWdata[$];
    logic [7:0]  txQ[$];
    int          txFrameErrs = 0;
    int          nonseqCycles = 0;
    logic [7:0]  monByte;

    // Count every cycle the bridge presents NONSEQ, so a stretched address phase shows up.
    always @(negedge hclk) begin
        if (!rst && bus.htrans == 2'b10) nonseqCycles <= nonseqCycles + 1;
    end

    // Slave model: accepts the address phase, then wait states, then OKAY or two-cycle ERROR.
    initial begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = '0;
        forever begin
            @(negedge hclk);
            if (!rst && bus.htrans == 2'b10) begin
                txnAddr.push_back(bus.haddr);
                txnWrite.push_back(bus.hwrite);
                txnBusy.push_back(busy);
                for (int w = 0; w < slvWait; w++) begin
                    @(negedge hclk);
                    if (rst) break;
                    bus.hready = 1'b0;
                end
                if (!rst) begin
                    if (slvErr) begin
                        @(negedge hclk);
                        bus.hready = 1'b0;
                        bus.hresp  = 1'b1;
                        @(negedge hclk);
                        bus.hready = 1'b1;
                    end else begin
                        @(negedge hclk);
                        bus.hready = 1'b1;
                        bus.hrdata = slvRdata;
                    end
                    txnWdata.push_back(bus.hwdata);
                    @(negedge hclk);
                    bus.hrdata = $urandom;
                end
                bus.hready = 1'b1;
                bus.hresp  = 1'b0;
            end
        end
    end

    // Serial receiver on TXD: mid-bit sampling, collects bytes and stop-bit errors.
    initial begin
        forever begin
            @(negedge TXD);
            repeat (BAUD / 2) @(posedge hclk);
            #1;
            if (TXD == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(posedge hclk);
                    #1;
                    monByte[i] = TXD;
                end
                repeat (BAUD) @(posedge hclk);
                #1;
                if (TXD !== 1'b1) txFrameErrs++;
                txQ.push_back(monByte);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit badStop);
        RXD = 1'b0;
        waitCycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            waitCycles(BAUD);
        end
        RXD = ~badStop;
        waitCycles(BAUD);
        RXD = 1'b1;
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data);
        sendByte(isWrite ? 8'h57 : 8'h52, 1'b0);
        for (int i = 0; i < 4; i++) sendByte(addr[8*i +: 8], 1'b0);
        if (isWrite) for (int i = 0; i < 4; i++) sendByte(data[8*i +: 8], 1'b0);
    endtask

    // One complete command: drive it, then compare bus transfer and reply with the model.
    task automatic runFrame(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ws, input bit err, input logic [31:0] rdata, input string tag);
        logic [7:0] expQ[$];
        logic [7:0] got;
        int txBase, txnBase, nsBase, feBase, limit;
        slvWait  = ws;
        slvErr   = err;
        slvRdata = rdata;
        txBase   = txQ.size();
        txnBase  = txnAddr.size();
        nsBase   = nonseqCycles;
        feBase   = txFrameErrs;
        if (err)          expQ.push_back(8'h45);
        else if (isWrite) expQ.push_back(8'h4B);
        else for (int i = 0; i < 4; i++) expQ.push_back(rdata[8*i +: 8]);

        applyStimulus(isWrite, addr, wdata);
        checkOutput({tag, "/busyAfterFrame"}, 32'(busy), 32'd1);

        limit = (expQ.size() + 1) * 12 * BAUD + ws + 50;
        while (txQ.size() < txBase + expQ.size() && limit > 0) begin
            waitCycles(1);
            limit--;
        end
        checkOutput({tag, "/replyInTime"}, 32'(limit > 0), 32'd1);
        waitCycles(BAUD + 4);

        checkOutput({tag, "/busyIdle"}, 32'(busy), 32'd0);
        checkOutput({tag, "/replyLen"}, 32'(txQ.size() - txBase), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            got = (txBase + i < txQ.size()) ? txQ[txBase + i] : 8'hxx;
            checkOutput($sformatf("%s/reply%0d", tag, i), 32'(got), 32'(expQ[i]));
        end
        checkOutput({tag, "/txStop"}, 32'(txFrameErrs - feBase), 32'd0);
        checkOutput({tag, "/txnCount"}, 32'(txnAddr.size() - txnBase), 32'd1);
        checkOutput({tag, "/nonseqCycles"}, 32'(nonseqCycles - nsBase), 32'd1);
        if (txnAddr.size() > txnBase) begin
            checkOutput({tag, "/haddr"}, txnAddr[txnBase], {addr[31:2], 2'b00});
            checkOutput({tag, "/hwrite"}, 32'(txnWrite[txnBase]), 32'(isWrite));
            checkOutput({tag, "/busyOnBus"}, 32'(txnBusy[txnBase]), 32'd1);
            if (isWrite && txnWdata.size() > txnBase)
                checkOutput({tag, "/hwdata"}, txnWdata[txnBase], wdata);
        end
    endtask

    task automatic checkQuiet(input string tag, input int txBase, input int txnBase);
        checkOutput({tag, "/busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "/noTx"}, 32'(txQ.size() - txBase), 32'd0);
        checkOutput({tag, "/noBus"}, 32'(txnAddr.size() - txnBase), 32'd0);
    endtask

    initial begin
        int txB, txnB, limit;
        bit w, e;
        logic [31:0] a, d;

        rst = 1'b1;
        RXD = 1'b1;
        waitCycles(4);
        checkOutput("reset/TXD", 32'(TXD), 32'd1);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        checkOutput("reset/htrans", 32'(bus.htrans), 32'd0);
        checkOutput("reset/haddr", bus.haddr, 32'd0);
        checkOutput("reset/hwrite", 32'(bus.hwrite), 32'd0);
        checkOutput("reset/hwdata", bus.hwdata, 32'd0);
        checkOutput("const/hsize", 32'(bus.hsize), 32'd2);
        checkOutput("const/hburst", 32'(bus.hburst), 32'd0);
        checkOutput("const/hprot", 32'(bus.hprot), 32'd3);
        checkOutput("const/hmastlock", 32'(bus.hmastlock), 32'd0);
        rst = 1'b0;
        waitCycles(2 * BAUD);

        runFrame(1'b1, 32'h80000010, 32'hDEADBEEF, 0, 1'b0, 32'h0, "writeOk");
        runFrame(1'b0, 32'h80000004, 32'h0, 3, 1'b0, 32'h12345678, "readWait3");
        runFrame(1'b0, 32'h00000003, 32'h0, 0, 1'b1, 32'hCAFEF00D, "readErr");
        runFrame(1'b1, 32'h0000002A, 32'h01020304, 2, 1'b1, 32'h0, "writeErr");

        // junk command byte, short glitch, then a write frame broken by a bad stop bit
        txB = txQ.size();
        txnB = txnAddr.size();
        sendByte(8'h41, 1'b0);
        waitCycles(2);
        checkOutput("junk/busy", 32'(busy), 32'd0);
        RXD = 1'b0;
        waitCycles(BAUD / 4);
        RXD = 1'b1;
        waitCycles(3 * BAUD);
        checkOutput("glitch/busy", 32'(busy), 32'd0);
        sendByte(8'h57, 1'b0);
        for (int i = 0; i < 4; i++) sendByte(8'h10 + 8'(i), 1'b0);
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b1);
        waitCycles(4 * BAUD);
        checkQuiet("badStop", txB, txnB);
        runFrame(1'b1, $urandom, $urandom, 1, 1'b0, 32'h0, "afterBadStop");

        // inter-byte timeout after two bytes of a write frame
        txB = txQ.size();
        txnB = txnAddr.size();
        sendByte(8'h57, 1'b0);
        sendByte(8'h10, 1'b0);
        checkOutput("timeout/busyStart", 32'(busy), 32'd1);
        waitCycles(62 * BAUD);
        checkOutput("timeout/busyBefore", 32'(busy), 32'd1);
        waitCycles(3 * BAUD);
        checkQuiet("timeout", txB, txnB);
        runFrame(1'b1, 32'h40000100, $urandom, 0, 1'b0, 32'h0, "afterTimeout");

        // randomized frames against the model
        for (int n = 0; n < 6; n++) begin
            w = 1'($urandom);
            e = ($urandom_range(0, 3) == 0);
            a = $urandom;
            d = $urandom;
            runFrame(w, a, d, $urandom_range(0, 4), e, $urandom, $sformatf("rand%0d", n));
        end

        // reset while the slave is stalling the data phase
        slvWait = 40;
        slvErr  = 1'b0;
        txnB = txnAddr.size();
        applyStimulus(1'b0, $urandom, 32'h0);
        limit = 100;
        while (txnAddr.size() == txnB && limit > 0) begin
            waitCycles(1);
            limit--;
        end
        checkOutput("rstBus/reachedBus", 32'(limit > 0), 32'd1);
        waitCycles(5);
        rst = 1'b1;
        #1;
        checkOutput("rstBus/htrans", 32'(bus.htrans), 32'd0);
        checkOutput("rstBus/TXD", 32'(TXD), 32'd1);
        checkOutput("rstBus/busy", 32'(busy), 32'd0);
        waitCycles(3);
        rst = 1'b0;
        waitCycles(2 * BAUD);
        runFrame(1'b0, $urandom, 32'h0, 0, 1'b0, $urandom, "afterRstBus");

        // reset while the second reply byte is on the line
        slvWait  = 0;
        slvRdata = $urandom;
        txB = txQ.size();
        applyStimulus(1'b0, $urandom, 32'h0);
        limit = 20 * BAUD;
        while (txQ.size() == txB && limit > 0) begin
            waitCycles(1);
            limit--;
        end
        checkOutput("rstTx/firstByte", 32'(limit > 0), 32'd1);
        waitCycles(3 * BAUD);
        rst = 1'b1;
        #1;
        checkOutput("rstTx/TXD", 32'(TXD), 32'd1);
        checkOutput("rstTx/busy", 32'(busy), 32'd0);
        checkOutput("rstTx/htrans", 32'(bus.htrans), 32'd0);
        waitCycles(3);
        rst = 1'b0;
        waitCycles(14 * BAUD);
        checkOutput("rstTx/busyAfter", 32'(busy), 32'd0);
        runFrame(1'b1, $urandom, $urandom, 1, 1'b0, 32'h0, "afterRstTx");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_hasti_bridge.md
# uart_hasti_bridge

Serial-to-bus debug initiator: receives framed commands on a UART RX line and issues single-word HASTI (AHB-lite) master transfers, returning read data or acknowledgements on TX. It sits opposite the memory-mapped UART slave. It lets a host PC load and inspect memory and peripherals over the same 8N1 link without the core running. It connects as a second master ahead of the bus arbiter.

## Interface
- BAUD_DIV, 5208, hclk cycles per serial bit (9600 bps @ 50 MHz); legal range 8..65535.
- TIMEOUT_BITS, 64, bit periods of RX idle allowed between bytes of one frame before the frame is discarded.
- hclk  in  1  bus/system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RXD  in  1  serial input, idle high; asynchronous to hclk.
- TXD  out  1  serial output, idle high.
- busy  out  1  high from the first byte of a frame until its response stop bit completes.
- haddr  out  `HASTI_ADDR_WIDTH  transfer address; [1:0] always 2'b00.
- hwrite  out  1  1 = write.
- hsize  out  `HASTI_SIZE_WIDTH  constant 3'b010 (word).
- hburst  out  `HASTI_BURST_WIDTH  constant SINGLE (0).
- hmastlock  out  1  constant 0.
- hprot  out  `HASTI_PROT_WIDTH  constant 4'b0011.
- htrans  out  `HASTI_TRANS_WIDTH  IDLE or NONSEQ only.
- hwdata  out  `HASTI_BUS_WIDTH  write data, valid in data phase.
- hrdata  in  `HASTI_BUS_WIDTH  read data.
- hready  in  1  transfer complete / slave ready.
- hresp  in  1  1 = error.

## Operation
- Reset values: TXD=1, busy=0, htrans=IDLE, haddr=0, hwrite=0, hwdata=0; constant outputs as listed. Reset mid-frame or mid-transfer aborts everything immediately; no partial byte is ever sent.
- RX: RXD passes a 2-flop synchronizer. A falling edge in RX_IDLE starts a byte. The start bit is re-checked at BAUD_DIV/2; if high, return to idle (glitch). Data bits are sampled every BAUD_DIV thereafter, LSB first; the stop bit is sampled likewise. If the stop bit is 0 (framing error), the byte is dropped and the current frame aborts to IDLE.
- TX: start bit, 8 data bits LSB first, stop bit, BAUD_DIV cycles each; response bytes are sent back-to-back.
- Frame formats (multi-byte fields LSB first):
  - write: 0x57 'W', A0..A3, D0..D3. Response is 0x4B 'K' on OKAY, 0x45 'E' on ERROR.
  - read: 0x52 'R', A0..A3. Response is D0..D3 on OKAY, or the single byte 0x45 on ERROR.
- Any other command byte in IDLE is ignored silently; busy stays 0.
- Address bytes: haddr takes {A3,A2,A1,A0} with bits [1:0] cleared.
- FSM states and transitions:
  - IDLE→GET_ADDR on a valid command byte.
  - GET_ADDR (4 bytes) → GET_DATA (write) or BUS_ADDR (read).
  - GET_DATA (4 bytes) → BUS_ADDR.
  - BUS_ADDR → BUS_DATA.
  - BUS_DATA → SEND.
  - SEND → IDLE when the last stop bit ends.
- Inter-byte timeout: in GET_ADDR/GET_DATA, a counter runs while RX is idle. After TIMEOUT_BITS*BAUD_DIV cycles with no new start bit, the frame is discarded and the FSM returns to IDLE (busy=0).
- Bytes received during BUS_* or SEND are discarded. The host must wait for the response.

## Timing
- BUS_ADDR: htrans=NONSEQ, haddr/hwrite valid, held until a rising edge with hready=1. Then the FSM moves to BUS_DATA with htrans=IDLE.
- BUS_DATA: hwdata is driven from the first BUS_DATA cycle and held until a rising edge with hready=1. hrdata and hresp are captured at that edge.
- An ERROR response is accepted at the final hready=1 edge; the first-cycle hready=0 of the two-cycle error response is merely treated as wait.
- Minimum bus occupancy is 2 cycles (zero wait). Wait states extend BUS_ADDR/BUS_DATA without limit.
- The first response start bit goes low within 2 cycles of leaving BUS_DATA.
- RX byte latency: the byte is available 9.5 bit periods (±2 cycles of sync) after the start edge. The last frame byte's stop-bit sample triggers BUS_ADDR on the next cycle.
- busy rises the cycle after the command byte is accepted. It falls the cycle after the final TX stop bit completes, or on timeout or abort.

## Test plan
- Write OK (BAUD_DIV=16): send 57 10 00 00 80 EF BE AD DE → one NONSEQ write at haddr=0x80000010, hwdata=0xDEADBEEF; TXD returns 0x4B; busy high throughout the frame and response.
- Read with 3 wait states: send 52 04 00 00 80; slave returns 0x12345678 after hready is low for 3 cycles → htrans NONSEQ held for 1 cycle; TXD sends 78 56 34 12.
- Error: read at 0x00000003 with a two-cycle hresp=1 → haddr=0x00000000; TXD sends only 0x45; FSM returns to IDLE.
- Robustness: 0x41 junk byte, then a 1/4-bit RXD low glitch, then a 'W' frame with a bad stop bit in D1 → no bus activity, no TX; a following valid frame succeeds.
- Timeout: send 57 10 then go silent for 65 bit periods → busy drops; the next 57 is treated as a new command.
- Reset during BUS_DATA wait and during TX byte 2 → htrans=IDLE, TXD=1, busy=0 immediately; clean operation after release.
